// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter
//   Round-robin arbiter in front of a shared 16-way, 8-bit bus multiplexer.
//   It picks one owner among up to NUM_REQ requesters and drives the mux
//   Selector/Disable inputs. It also returns a one-hot grant to the owner.
//   Bus tenure is bounded to MAX_HOLD consecutive non-stalled cycles.
//
// Ports
//   clk          in   1   rising-edge clock
//   rst          in   1   synchronous reset, active-low
//   req          in   16  per-requester request; bits >= NUM_REQ ignored
//   stall        in   1   1 = freeze all state this cycle, req ignored
//   grant        out  16  one-hot grant to the current owner, 0 when idle
//   Selector     out  8   mux select = owner index, [7:4] always 0
//   Disable      out  1   1 = no owner, mux output disabled
//   busy         out  1   1 = bus owned (always ~Disable)
//   o_dbg_state  out  1   FSM state (0 = IDLE, 1 = OWNED) for observation
//
// Handshake: there is no valid/ready pair. A requester holds req[i] high
// for as long as it wants the bus. It owns the bus in every cycle where
// grant[i] is high. Dropping req[i] gives up ownership at the next edge.
// A request that drops before it is granted is simply forgotten.
//
// All outputs come straight from flops. Grant, Selector and Disable
// become valid one edge after the req that caused them.

module mux16_rr_arbiter #(
  parameter int UUID     = 0,
  parameter     NAME     = "",
  parameter int NUM_REQ  = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        stall,
  output logic [15:0] grant,
  output logic [7:0]  Selector,
  output logic        Disable,
  output logic        busy,
  output logic        o_dbg_state
);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  localparam logic [15:0] REQ_MASK = 16'((33'h1 << NUM_REQ) - 33'h1);
  localparam logic [3:0]  LAST_IDX = 4'(NUM_REQ - 1);
  localparam logic [7:0]  HOLD_MAX = 8'(MAX_HOLD);

  // Identification parameters are informational only.
  logic w_unused_params;
  assign w_unused_params = ^{UUID, NAME};

  state_t      r_state;
  state_t      w_state_n;
  logic [3:0]  r_rr_ptr;
  logic [3:0]  w_rr_ptr_n;
  logic [7:0]  r_hold_cnt;
  logic [7:0]  w_hold_cnt_n;
  logic [3:0]  r_owner;
  logic [3:0]  w_owner_n;
  logic [15:0] r_grant;
  logic        r_disable;
  logic        r_busy;

  logic [15:0] w_req;
  logic [3:0]  w_rel_ptr;
  logic [4:0]  w_pick_cur;
  logic [4:0]  w_pick_rel;
  logic [15:0] w_grant_n;

  assign w_req = req & REQ_MASK;

  // Pointer that takes effect if the current owner releases this cycle.
  assign w_rel_ptr = (r_owner == LAST_IDX) ? 4'd0 : (r_owner + 4'd1);

  // Returns {found, index}. The scan starts at ptr and wraps modulo NUM_REQ.
  function automatic logic [4:0] rr_pick(input logic [3:0] ptr,
                                         input logic [15:0] r);
    logic       found;
    logic [3:0] idx;
    int         c;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = int'(ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!found && r[c]) begin
        found = 1'b1;
        idx   = c[3:0];
      end
    end
    return {found, idx};
  endfunction

  assign w_pick_cur = rr_pick(r_rr_ptr, w_req);
  assign w_pick_rel = rr_pick(w_rel_ptr, w_req);

  always_comb begin
    w_state_n    = r_state;
    w_rr_ptr_n   = r_rr_ptr;
    w_hold_cnt_n = r_hold_cnt;
    w_owner_n    = r_owner;
    if (!stall) begin
      case (r_state)
        IDLE: begin
          // A grant from IDLE leaves the pointer alone.
          if (w_pick_cur[4]) begin
            w_state_n    = OWNED;
            w_owner_n    = w_pick_cur[3:0];
            w_hold_cnt_n = 8'd1;
          end
        end
        OWNED: begin
          if (w_req[r_owner] && (r_hold_cnt < HOLD_MAX)) begin
            w_hold_cnt_n = r_hold_cnt + 8'd1;
          end else begin
            // Release, then re-arbitrate in the same edge from the
            // advanced pointer so no idle bubble appears between owners.
            w_rr_ptr_n = w_rel_ptr;
            if (w_pick_rel[4]) begin
              w_owner_n    = w_pick_rel[3:0];
              w_hold_cnt_n = 8'd1;
            end else begin
              // Owner index is kept so Selector holds its last value.
              w_state_n    = IDLE;
              w_hold_cnt_n = 8'd0;
            end
          end
        end
        default: begin
          w_state_n    = IDLE;
          w_hold_cnt_n = 8'd0;
        end
      endcase
    end
  end

  assign w_grant_n = (w_state_n == OWNED) ? (16'h0001 << w_owner_n) : 16'h0000;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_rr_ptr   <= 4'd0;
      r_hold_cnt <= 8'd0;
      r_owner    <= 4'd0;
      r_grant    <= 16'h0000;
      r_disable  <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_rr_ptr   <= w_rr_ptr_n;
      r_hold_cnt <= w_hold_cnt_n;
      r_owner    <= w_owner_n;
      r_grant    <= w_grant_n;
      r_disable  <= (w_state_n == IDLE);
      r_busy     <= (w_state_n == OWNED);
    end
  end

  assign grant       = r_grant;
  assign Selector    = {4'b0000, r_owner};
  assign Disable     = r_disable;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed bench for mux16_rr_arbiter with the default parameters:
// NUM_REQ=16 and MAX_HOLD=8.
// Each step drives rst/stall/req and pushes the expected observation
// {grant, Selector, Disable, busy, state} onto exp_q. After the next
// rising edge it pops that entry and compares it with the DUT outputs.

module tb_mux16_rr_arbiter;

  localparam int W = 27;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        stall;
  logic [15:0] grant;
  logic [7:0]  Selector;
  logic        Disable;
  logic        busy;
  logic        o_dbg_state;

  logic [W-1:0] exp_q[$];
  logic [7:0]   last_sel;
  int           checks;
  int           errors;

  mux16_rr_arbiter #(
    .UUID(0),
    .NAME("arb0"),
    .NUM_REQ(16),
    .MAX_HOLD(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .stall(stall),
    .grant(grant),
    .Selector(Selector),
    .Disable(Disable),
    .busy(busy),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] onehot_index(input logic [15:0] g);
    logic [7:0] idx;
    idx = 8'd0;
    for (int i = 0; i < 16; i++) begin
      if (g[i]) idx = 8'(i);
    end
    return idx;
  endfunction

  // driver + scoreboard step: one clock edge per call
  task automatic step(input logic rst_v, input logic stall_v,
                      input logic [15:0] req_v, input logic [15:0] exp_g,
                      input string tag);
    logic [W-1:0] exp_v;
    logic [W-1:0] obs_v;
    logic [7:0]   exp_sel;
    logic         owned;
    rst   = rst_v;
    stall = stall_v;
    req   = req_v;
    owned = (exp_g != 16'h0000);
    if (!rst_v)     exp_sel = 8'h00;
    else if (owned) exp_sel = onehot_index(exp_g);
    else            exp_sel = last_sel;
    last_sel = exp_sel;
    exp_q.push_back({exp_g, exp_sel, ~owned, owned, owned});
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    obs_v = {grant, Selector, Disable, busy, o_dbg_state};
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s: observed grant/sel/dis/busy/st=%h/%h/%b/%b/%b expected %h/%h/%b/%b/%b",
             tag, obs_v[26:11], obs_v[10:3], obs_v[2], obs_v[1], obs_v[0],
             exp_v[26:11], exp_v[10:3], exp_v[2], exp_v[1], exp_v[0]);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    last_sel = 8'h00;
    rst      = 1'b0;
    stall    = 1'b0;
    req      = 16'h0000;

    // 1: reset dominates all-ones requests
    repeat (2) step(1'b0, 1'b0, 16'hFFFF, 16'h0000, "reset_hold");

    // 2: single requester 0; hold limit re-grants it with no Disable pulse
    repeat (8) step(1'b1, 1'b0, 16'h0001, 16'h0001, "solo0_tenure");
    step(1'b1, 1'b0, 16'h0001, 16'h0001, "solo0_regrant");

    // 3: 0 and 15 alternate every 8 cycles (owner 0 already has 1 cycle)
    repeat (7) step(1'b1, 1'b0, 16'h8001, 16'h0001, "alt_own0_a");
    repeat (8) step(1'b1, 1'b0, 16'h8001, 16'h8000, "alt_own15");
    repeat (8) step(1'b1, 1'b0, 16'h8001, 16'h0001, "alt_own0_b");
    step(1'b1, 1'b0, 16'h8001, 16'h8000, "alt_own15_again");

    // 4: owner 15 drops, ptr=0 -> 3; owner 3 drops with 0x14 -> 4 (ptr=4)
    step(1'b1, 1'b0, 16'h0008, 16'h0008, "drop15_to3");
    step(1'b1, 1'b0, 16'h0008, 16'h0008, "own3_hold");
    step(1'b1, 1'b0, 16'h0014, 16'h0010, "drop3_to4");
    repeat (7) step(1'b1, 1'b0, 16'h0014, 16'h0010, "own4_tenure");
    step(1'b1, 1'b0, 16'h0014, 16'h0004, "wrap_to2");
    repeat (7) step(1'b1, 1'b0, 16'h0014, 16'h0004, "own2_tenure");
    step(1'b1, 1'b0, 16'h0014, 16'h0010, "back_to4");
    // all requests drop: idle, Selector keeps 4
    repeat (2) step(1'b1, 1'b0, 16'h0000, 16'h0000, "idle_sel_hold");

    // 5: idle grant of 5 (ptr 5 unchanged), stall 3 cycles mid-tenure
    repeat (3) step(1'b1, 1'b0, 16'h0020, 16'h0020, "own5_pre_stall");
    step(1'b1, 1'b1, 16'h0040, 16'h0020, "stall_req_other");
    step(1'b1, 1'b1, 16'h0000, 16'h0020, "stall_req_none");
    step(1'b1, 1'b1, 16'h0040, 16'h0020, "stall_req_other2");
    repeat (5) step(1'b1, 1'b0, 16'h0020, 16'h0020, "own5_post_stall");
    step(1'b1, 1'b0, 16'h0020, 16'h0020, "own5_limit_regrant");
    step(1'b1, 1'b0, 16'h0020, 16'h0020, "own5_new_tenure");

    // 6: reset mid-tenure (also with stall high) drops grant; ptr back to 0
    step(1'b0, 1'b1, 16'h0020, 16'h0000, "reset_over_stall");
    step(1'b0, 1'b0, 16'h0020, 16'h0000, "reset_mid");
    step(1'b1, 1'b0, 16'h0041, 16'h0001, "ptr_reset_pick0");
    step(1'b1, 1'b0, 16'h0040, 16'h0040, "drop0_to6");
    step(1'b1, 1'b0, 16'h0000, 16'h0000, "final_idle");

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d entries expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
